fetch: RTL
==========

Name: fetch

Overview:
Instruction fetch front end that produces the 32-bit instruction word consumed by the decode stage. It keeps the fetch PC and issues sequential word requests to instruction memory. Returned instructions are buffered in a small FIFO together with their PCs and handed to decode through a valid/ready handshake. A redirect from branch/jump resolution flushes the buffer, moves the fetch PC to the target, and drops any responses still in flight.

Parameters:
RESET_PC  32'h0000_0000  PC fetched first after reset
BUF_DEPTH  2  instruction buffer entries and max total in-flight credit; power of 2, >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address (bits [1:0] always 0)
imem_rsp_valid  input  1  response valid; in order, one per accepted request, never back-pressured
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  redirect fetch (taken branch/jump)
redirect_pc  input  32  redirect target
instr_valid  output  1  instr/instr_pc valid to decode
instr_ready  input  1  decode consumes head instruction
instr  output  32  instruction word to decode
instr_pc  output  32  PC of instr

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on clk rising edge.
- Reset values:
  - fetch_pc = RESET_PC.
  - Buffer empty; live_inflight = 0; drop_cnt = 0.
  - instr_valid = 0; imem_req_valid = 0 in the reset cycle.
  - instr = 32'h0000_0013 (NOP) whenever instr_valid = 0; instr_pc = 0 then.
- Instruction memory is reset by the same reset, so no pre-reset response ever arrives after reset. Reset mid-operation discards all state.
- Request issue:
  - credit = live_inflight + drop_cnt + occupancy − pop, where pop = instr_valid & instr_ready.
  - imem_req_valid = ~reset & ~redirect_valid & (credit < BUF_DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake (valid & ready), fetch_pc += 4 and live_inflight++.
  - With imem_req_ready low, addr holds stable. A request is withdrawn only in a redirect cycle.
- Response:
  - If drop_cnt > 0 at arrival, the response is discarded and drop_cnt-- (this includes the redirect cycle itself; see redirect).
  - Otherwise {pc_tag, data} is pushed to the buffer and live_inflight--.
  - pc_tag comes from a PC counter rsp_pc. rsp_pc starts at RESET_PC, is loaded with the redirect target on redirect, and advances by 4 per pushed response.
- Output:
  - instr_valid = buffer non-empty; instr/instr_pc = buffer head.
  - Registered FIFO, no bypass: a response in cycle N is visible in cycle N+1.
  - Sustains one instruction per cycle with 1-cycle memory at BUF_DEPTH = 2.
- Redirect (redirect_valid = 1 in cycle N):
  - Next cycle: fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}. Low bits are silently cleared.
  - Buffer flushed (occupancy 0).
  - drop_cnt = drop_cnt + live_inflight − (response arriving in N that would otherwise be live ? 1 : 0). live_inflight = 0.
  - Any imem response in cycle N is discarded.
  - No request issues in cycle N.
  - A pop in cycle N counts as consumed; decode owns that instruction.
  - redirect_valid in consecutive cycles: the last target wins; drop accounting accumulates.
- Simultaneous push and pop on the buffer is legal and keeps occupancy constant.
- Overflow is impossible by construction: a response arriving when the buffer is full is an assertion failure.
- All counters are clog2(BUF_DEPTH)+1 bits wide. Assertions:
  - live_inflight + drop_cnt + occupancy <= BUF_DEPTH.
  - drop_cnt never underflows.

Decomposition:
- defines.svh gets NOP_INSTR = 32'h0000_0013 and INSTR_BYTES = 4.
- No new typedefs.
- One sub-module, fetch_buffer: a synchronous FIFO of BUF_DEPTH entries × 64 bits {pc, instr}.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push in the same cycle.

Test Plan:
1. Reset with RESET_PC = 0; memory always ready with 1-cycle latency; instr_ready = 1 -> addrs 0, 4, 8, … one per cycle; first instr_valid two cycles after the first request with instr_pc = 0; then one instruction per cycle in PC order.
2. Hold instr_ready = 0 -> exactly two requests (0, 4), then imem_req_valid stays low; buffer holds pc 0 and pc 4. Raise instr_ready -> pc 0 and pc 4 drain, requests resume at 8.
3. 3-cycle memory latency, redirect_pc = 0x100 while two requests (8, 12) are in flight -> next request addr is 0x100; both stale responses are dropped; the next instr_valid carries instr_pc 0x100.
4. Redirect in the same cycle as a response and a pop -> the response is discarded, the popped instruction leaves normally, the buffer is empty next cycle, drop_cnt stays consistent (no underflow assertion).
5. redirect_pc = 0x0000_0203 -> imem_req_addr = 0x0000_0200 and instr_pc = 0x200.
6. imem_req_ready held low 4 cycles with req pending at 0x40 -> addr stays 0x40 and valid stays high; fetch_pc advances only on the handshake. A reset pulse mid-stream -> the next request is at RESET_PC with instr_valid = 0 and instr = 0x13.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants for the instruction fetch front end.
// Revision : 1.0
// ============================================================================
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;
endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Registered FIFO of {pc, instr} entries; flush wins over push.
// Revision : 1.0
// ============================================================================
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Brief    : Fetch PC, credit-limited imem requests, instruction buffer, redirect.
// Revision : 1.0
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             w_full, w_empty;
    logic [CNT_W-1:0] w_occ;
    logic [63:0]      w_head;
    logic             w_pop, w_fire, w_rsp_live, w_rsp_drop, w_push;
    logic [CNT_W:0]   w_credit;
    logic [31:0]      w_target;

    assign w_pop      = instr_valid & instr_ready;
    assign w_credit   = {1'b0, live_q} + {1'b0, drop_q} + {1'b0, w_occ} - (CNT_W+1)'(w_pop);
    assign w_rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign w_rsp_live = imem_rsp_valid & (drop_q == '0);
    assign w_push     = w_rsp_live & ~redirect_valid;
    assign w_target   = redirect_pc & ~32'h3;

    assign imem_req_valid = ~reset & ~redirect_valid & (w_credit < (CNT_W+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign w_fire         = imem_req_valid & imem_req_ready;

    assign instr_valid = ~w_empty;
    assign instr       = w_empty ? NOP_INSTR : w_head[31:0];
    assign instr_pc    = w_empty ? 32'h0     : w_head[63:32];

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_occ),
        .head      (w_head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q - CNT_W'(w_rsp_drop);
        if (redirect_valid) begin
            fetch_pc_d = w_target;
            rsp_pc_d   = w_target;
            live_d     = '0;
            // Everything still outstanding becomes stale, except a live response landing now.
            drop_d     = drop_q - CNT_W'(w_rsp_drop) + live_q - CNT_W'(w_rsp_live);
        end else begin
            if (w_fire) begin
                fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
            end
            if (w_push) begin
                rsp_pc_d = rsp_pc_q + 32'(INSTR_BYTES);
            end
            live_d = live_q + CNT_W'(w_fire) - CNT_W'(w_rsp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            assert ({1'b0, live_q} + {1'b0, drop_q} + {1'b0, w_occ} <= (CNT_W+1)'(BUF_DEPTH));
            assert (!(imem_rsp_valid && live_q == '0 && drop_q == '0));
            assert (!(w_push && w_full && !w_pop));
        end
    end
endmodule
`default_nettype wire
